// File: rtl/pair_triple_bist_pkg.sv
// Shared widths, sweep length and FSM state encoding for the pair/triple detector BIST.
package pair_triple_bist_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/pair_triple_ref.sv
// Golden model of the detector: output is 1 when two or more inputs are 1.
module pair_triple_ref (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic expected_c
);

    // Majority of three inputs
    assign expected_c = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/pair_triple_bist.sv
// Self-test engine: sweeps all input vectors into the detector, compares its
// output against the golden model and reports pass/fail, count and first failure.
module pair_triple_bist
    import pair_triple_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             drv_in0,
    output logic             drv_in1,
    output logic             drv_in2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             fail_seen
);

    localparam logic [CNT_W-1:0] SCNT_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VECTORS - 1);

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [CNT_W-1:0]   scnt;
    logic [VEC_W-1:0]   drv_vec;
    logic               expected_c;
    logic               mismatch_c;
    logic [CNT_W-1:0]   fail_count_nxt_c;

    assign drv_in0 = drv_vec[2];
    assign drv_in1 = drv_vec[1];
    assign drv_in2 = drv_vec[0];

    pair_triple_ref u_ref (
        .in0        (vec[2]),
        .in1        (vec[1]),
        .in2        (vec[0]),
        .expected_c (expected_c)
    );

    // Compare sampled detector output with the golden value for the current vector
    always_comb begin
        mismatch_c       = (dut_out != expected_c);
        fail_count_nxt_c = fail_count + CNT_W'(mismatch_c);
    end

    // Sweep FSM with registered drive, status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= '0;
            scnt           <= '0;
            drv_vec        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SETTLE;
                        vec            <= '0;
                        scnt           <= SCNT_INIT;
                        drv_vec        <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_vec <= '0;
                        fail_seen      <= 1'b0;
                    end
                end
                SETTLE: begin
                    scnt <= scnt - CNT_W'(1);
                    if (scnt <= CNT_W'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch_c) begin
                        fail_count <= fail_count_nxt_c;
                        if (!fail_seen) begin
                            first_fail_vec <= vec;
                            fail_seen      <= 1'b1;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state   <= DONE;
                        drv_vec <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (fail_count_nxt_c == '0);
                    end else begin
                        state   <= SETTLE;
                        vec     <= vec + VEC_W'(1);
                        drv_vec <= vec + VEC_W'(1);
                        scnt    <= SCNT_INIT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_triple_bist.sv
// Randomized self-checking bench: two BIST instances (settle 1 and 3) each drive a
// behavioural detector with a per-vector fault mask; results checked every cycle.
module tb_pair_triple_bist;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic       a_in0, a_in1, a_in2, a_out, a_busy, a_done, a_pass, a_seen;
    logic [3:0] a_cnt;
    logic [2:0] a_ffv;
    logic       b_in0, b_in1, b_in2, b_out, b_busy, b_done, b_pass, b_seen;
    logic [3:0] b_cnt;
    logic [2:0] b_ffv;

    logic [7:0] mask_a = 8'h00;
    logic [7:0] mask_b = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Correct detector: two or more ones
    function automatic logic maj(input int v);
        logic [2:0] b3;
        b3 = v[2:0];
        return ($countones(b3) >= 2);
    endfunction

    // Mask bit set => detector answers wrongly for that vector
    function automatic logic [7:0] stuck_mask(input logic val);
        logic [7:0] m;
        for (int v = 0; v < 8; v++) m[v] = (maj(v) != val);
        return m;
    endfunction

    assign a_out = maj(int'({a_in0, a_in1, a_in2})) ^ mask_a[{a_in0, a_in1, a_in2}];
    assign b_out = maj(int'({b_in0, b_in1, b_in2})) ^ mask_b[{b_in0, b_in1, b_in2}];

    pair_triple_bist #(.SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .drv_in0(a_in0), .drv_in1(a_in1), .drv_in2(a_in2), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail_count(a_cnt),
        .first_fail_vec(a_ffv), .fail_seen(a_seen)
    );

    pair_triple_bist #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .drv_in0(b_in0), .drv_in1(b_in1), .drv_in2(b_in2), .dut_out(b_out),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_count(b_cnt),
        .first_fail_vec(b_ffv), .fail_seen(b_seen)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected state of one unit k cycles after busy rose, from the vector schedule
    task automatic check_unit(input string nm, input int s, input int k, input logic [7:0] m,
                              input logic bsy, input logic dn, input logic ps,
                              input logic [2:0] drv, input logic [3:0] cnt,
                              input logic [2:0] ffv, input logic seen);
        int per, completed, fails, first;
        per = s + 1;
        completed = (k < 8 * per) ? k / per : 8;
        fails = 0;
        first = -1;
        for (int i = 0; i < completed; i++) begin
            if (m[i]) begin
                fails++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("%s.busy k=%0d", nm, k), 32'(bsy), 32'(k < 8 * per));
        chk($sformatf("%s.done k=%0d", nm, k), 32'(dn),  32'(k >= 8 * per));
        chk($sformatf("%s.pass k=%0d", nm, k), 32'(ps),  32'((k >= 8 * per) && fails == 0));
        chk($sformatf("%s.drv k=%0d",  nm, k), 32'(drv), (k < 8 * per) ? 32'(k / per) : 32'd0);
        chk($sformatf("%s.cnt k=%0d",  nm, k), 32'(cnt), 32'(fails));
        chk($sformatf("%s.ffv k=%0d",  nm, k), 32'(ffv), (first < 0) ? 32'd0 : 32'(first));
        chk($sformatf("%s.seen k=%0d", nm, k), 32'(seen), 32'(fails > 0));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".a"}, {24'd0, a_busy, a_done, a_pass, a_seen, a_in0, a_in1, a_in2, 1'b0}, 32'd0);
        chk({tag, ".a_res"}, {25'd0, a_cnt, a_ffv}, 32'd0);
        chk({tag, ".b"}, {24'd0, b_busy, b_done, b_pass, b_seen, b_in0, b_in1, b_in2, 1'b0}, 32'd0);
        chk({tag, ".b_res"}, {25'd0, b_cnt, b_ffv}, 32'd0);
    endtask

    // Start pulse then check both units every cycle through completion; optional mid-sweep start
    task automatic run_sweep(input logic [7:0] ma, input logic [7:0] mb, input int mid_k);
        mask_a = ma;
        mask_b = mb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            check_unit("a", 1, k, ma, a_busy, a_done, a_pass, {a_in0, a_in1, a_in2}, a_cnt, a_ffv, a_seen);
            check_unit("b", 3, k, mb, b_busy, b_done, b_pass, {b_in0, b_in1, b_in2}, b_cnt, b_ffv, b_seen);
            start = (k == mid_k);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        run_sweep(8'h00, 8'h00, -1);
        run_sweep(stuck_mask(1'b0), stuck_mask(1'b0), -1);
        run_sweep(stuck_mask(1'b1), 8'hFF, -1);
        run_sweep(8'h00, 8'h00, 5);
        for (int r = 0; r < 5; r++) begin
            run_sweep(8'($urandom), 8'($urandom), (r == 2) ? int'($urandom_range(0, 14)) : -1);
        end

        // Reset on the fifth busy cycle
        mask_a = 8'h00;
        mask_b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst.busy", 32'({a_busy, b_busy}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");
        @(negedge clk);
        check_idle("post_rst");

        // Start coincident with reset is dropped
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_idle("rst_start");
        @(negedge clk);
        check_idle("rst_start2");

        run_sweep(8'h00, 8'h00, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
